// File: rtl/snake_game_ctrl_if.sv
// snake_game_ctrl_if: game inputs from movement/LFSR logic and score outputs to the display
interface snake_game_ctrl_if;
  logic tick;
  logic start;
  logic [7:0] snake_pos;
  logic [7:0] rand_val;
  logic [7:0] rabbit_pos;
  logic [15:0] score;
  logic eat;
  logic game_over;
  logic [15:0] hiscore;
  modport master(output tick, start, snake_pos, rand_val, input rabbit_pos, score, eat, game_over, hiscore);
  modport slave(input tick, start, snake_pos, rand_val, output rabbit_pos, score, eat, game_over, hiscore);
endinterface

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: rabbit spawn/eat/timeout sequencer with saturating BCD score
// Define SNAKE_HISCORE_EN to keep a best-score register on hiscore.
module snake_game_ctrl #(
  parameter int TIMEOUT_TICKS = 64
) (
  input logic clk,
  input logic rst_n,
  snake_game_ctrl_if.slave io
);
  typedef enum logic [2:0] {IDLE, SPAWN, HUNT, EAT, OVER} state_t;
  state_t state, state_n;
  logic [7:0] rabbit, rabbit_n, cnt, cnt_n, cand;
  logic [15:0] score, score_n;
  logic eat, game_over, match, restart, timeout;
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic c;
    r = v;
    c = 1'b1;
    if (v == 16'h9999) return v;
    for (int i = 0; i < 4; i++)
      if (c) begin
        if (r[i*4+:4] == 4'd9) r[i*4+:4] = 4'd0;
        else begin
          r[i*4+:4] = r[i*4+:4] + 4'd1;
          c = 1'b0;
        end
      end
    return r;
  endfunction
  assign cand = 8'd1 << io.rand_val[2:0];
  assign match = (io.snake_pos == rabbit) && |rabbit;
  assign restart = io.start && (state == SPAWN || state == HUNT || state == EAT);
  assign timeout = io.tick && cnt == 8'(TIMEOUT_TICKS - 1);
  // start outranks everything; within HUNT a match outranks the timeout
  always_comb begin
    state_n = state;
    rabbit_n = rabbit;
    score_n = score;
    cnt_n = cnt;
    if (restart) begin
      state_n = SPAWN;
      rabbit_n = '0;
      score_n = '0;
    end else
      case (state)
        IDLE, OVER: if (io.start) begin
          state_n = SPAWN;
          score_n = '0;
        end
        SPAWN: if (cand != io.snake_pos) begin
          rabbit_n = cand;
          cnt_n = '0;
          state_n = HUNT;
        end
        HUNT: if (match) begin
          rabbit_n = '0;
          score_n = bcd_inc(score);
          state_n = EAT;
        end else if (timeout) begin
          rabbit_n = '0;
          state_n = OVER;
        end else if (io.tick) cnt_n = cnt + 8'd1;
        EAT: state_n = SPAWN;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rabbit <= '0;
      score <= '0;
      cnt <= '0;
      eat <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state <= state_n;
      rabbit <= rabbit_n;
      score <= score_n;
      cnt <= cnt_n;
      eat <= state_n == EAT;
      game_over <= state_n == OVER;
    end
  assign io.rabbit_pos = rabbit;
  assign io.score = score;
  assign io.eat = eat;
  assign io.game_over = game_over;
`ifdef SNAKE_HISCORE_EN
  logic [15:0] hiscore;
  logic hi_upd;
  // digit-wise BCD order matches plain binary order
  assign hi_upd = (restart || (state == HUNT && state_n == OVER)) && score > hiscore;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hiscore <= '0;
    else if (hi_upd) hiscore <= score;
  assign io.hiscore = hiscore;
`else
  assign io.hiscore = 16'h0000;
`endif
endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb_snake_game_ctrl: directed checks of spawn, eat, BCD carry/saturation, timeout and hiscore
module tb_snake_game_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
`ifdef SNAKE_HISCORE_EN
  localparam logic [15:0] HI12 = 16'h0012;
`else
  localparam logic [15:0] HI12 = 16'h0000;
`endif
  snake_game_ctrl_if io();
  snake_game_ctrl #(.TIMEOUT_TICKS(4)) dut (.clk(clk), .rst_n(rst_n), .io(io));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic nclk(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic eat_one(output logic e);
    io.snake_pos = 8'h20;
    nclk();
    e = io.eat;
    io.snake_pos = 8'h01;
    nclk(2);
  endtask
  function automatic logic [15:0] bcd(input int n);
    int m;
    m = n > 9999 ? 9999 : n;
    return {4'(m / 1000), 4'(m / 100 % 10), 4'(m / 10 % 10), 4'(m % 10)};
  endfunction
  initial begin
    logic e;
    io.tick = 1'b0;
    io.start = 1'b0;
    io.snake_pos = 8'h00;
    io.rand_val = 8'h00;
    nclk(2);
    check("rst_rabbit", 16'(io.rabbit_pos), 16'h0);
    check("rst_score", io.score, 16'h0);
    check("rst_eat", 16'(io.eat), 16'h0);
    check("rst_over", 16'(io.game_over), 16'h0);
    check("rst_hi", io.hiscore, 16'h0);
    rst_n = 1'b1;
    io.start = 1'b1;
    io.rand_val = 8'h03;
    io.snake_pos = 8'h01;
    nclk();
    io.start = 1'b0;
    check("start_k", 16'(io.rabbit_pos), 16'h0);
    nclk();
    check("start_k1", 16'(io.rabbit_pos), 16'h08);
    io.snake_pos = 8'h08;
    nclk();
    check("eat_pulse", 16'(io.eat), 16'h1);
    check("eat_score", io.score, 16'h0001);
    check("eat_rabbit", 16'(io.rabbit_pos), 16'h0);
    io.snake_pos = 8'h01;
    nclk();
    check("eat_low", 16'(io.eat), 16'h0);
    check("respawn_k1", 16'(io.rabbit_pos), 16'h0);
    nclk();
    check("respawn_k2", 16'(io.rabbit_pos), 16'h08);
    io.snake_pos = 8'h08;
    nclk();
    io.snake_pos = 8'h01;
    nclk(2);
    check("hunt_score", io.score, 16'h0002);
    check("hunt_rabbit", 16'(io.rabbit_pos), 16'h08);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rabbit", 16'(io.rabbit_pos), 16'h0);
    check("arst_score", io.score, 16'h0);
    check("arst_eat", 16'(io.eat), 16'h0);
    check("arst_over", 16'(io.game_over), 16'h0);
    nclk();
    rst_n = 1'b1;
    nclk(2);
    check("idle_hold", 16'(io.rabbit_pos), 16'h0);
    io.snake_pos = 8'h10;
    io.rand_val = 8'h04;
    io.start = 1'b1;
    nclk();
    io.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nclk();
      check("retry", 16'(io.rabbit_pos), 16'h0);
    end
    io.rand_val = 8'h05;
    nclk();
    check("retry_done", 16'(io.rabbit_pos), 16'h20);
    io.snake_pos = 8'h01;
    for (int i = 1; i <= 10000; i++) begin
      eat_one(e);
      if (i == 1 || i == 19 || i == 20 || i == 100 || i == 1000 || i == 9999 || i == 10000)
        check($sformatf("bcd_%0d", i), io.score, bcd(i));
      if (i == 10000) check("sat_eat", 16'(e), 16'h1);
    end
    rst_n = 1'b0;
    nclk();
    rst_n = 1'b1;
    check("rst2_score", io.score, 16'h0);
    io.start = 1'b1;
    nclk();
    io.start = 1'b0;
    nclk();
    for (int i = 0; i < 12; i++) eat_one(e);
    check("g1_score", io.score, 16'h0012);
    io.tick = 1'b1;
    nclk(3);
    io.tick = 1'b0;
    check("to_3ticks", 16'(io.game_over), 16'h0);
    io.tick = 1'b1;
    nclk();
    io.tick = 1'b0;
    check("to_over", 16'(io.game_over), 16'h1);
    check("to_rabbit", 16'(io.rabbit_pos), 16'h0);
    check("to_score", io.score, 16'h0012);
    check("g1_hi", io.hiscore, HI12);
    nclk(2);
    check("over_hold", io.score, 16'h0012);
    check("over_stay", 16'(io.game_over), 16'h1);
    io.start = 1'b1;
    nclk();
    io.start = 1'b0;
    check("g2_score0", io.score, 16'h0);
    check("g2_over0", 16'(io.game_over), 16'h0);
    nclk();
    for (int i = 0; i < 6; i++) eat_one(e);
    io.tick = 1'b1;
    nclk(3);
    check("tie_pre", 16'(io.game_over), 16'h0);
    io.snake_pos = 8'h20;
    nclk();
    io.tick = 1'b0;
    io.snake_pos = 8'h01;
    check("tie_eat", 16'(io.eat), 16'h1);
    check("tie_score", io.score, 16'h0007);
    check("tie_over", 16'(io.game_over), 16'h0);
    nclk(2);
    io.tick = 1'b1;
    nclk(4);
    io.tick = 1'b0;
    check("g2_over", 16'(io.game_over), 16'h1);
    check("g2_score", io.score, 16'h0007);
    check("g2_hi", io.hiscore, HI12);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
